// File: rtl/system_qsys_nios2_oci_pkg.sv
// Shared encodings for the Nios II OCI memory arbiter: JTAG op codes,
// arbiter FSM states and the jdo field layout.
package system_qsys_nios2_oci_pkg;

    typedef enum logic [1:0] {
        OP_RD     = 2'd0,
        OP_RD_INC = 2'd1,
        OP_WR_INC = 2'd2
    } op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_RD  = 2'd1,
        JTAG_RD = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_CPU  = 1'b0,
        GRANT_JTAG = 1'b1
    } grant_t;

    localparam int unsigned JDO_DATA_MSB   = 34;
    localparam int unsigned JDO_DATA_LSB   = 3;
    localparam int unsigned JDO_ADDR_LSB   = 10;
    localparam int unsigned JDO_LDADDR_BIT = 34;

endpackage

// File: rtl/system_qsys_nios2_ocimem_jtag_req.sv
// One-deep pending slot for JTAG OCI memory actions: strobe priority,
// capture of op/address/data, and the sticky overrun flag.
module system_qsys_nios2_ocimem_jtag_req
    import system_qsys_nios2_oci_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              slot_grant,
    input  logic              slot_wr_grant,
    input  logic              jtag_rd_active,
    output logic              pending,
    output op_t               pend_op,
    output logic              pend_ld,
    output logic [ADDR_W-1:0] pend_addr,
    output logic [31:0]       pend_data,
    output logic              overrun
);

    logic any_strobe;
    logic multi_strobe;
    logic slot_free;
    logic accept;
    op_t  next_op;
    logic next_ld;
    logic [5:0] jdo_unused;

    assign jdo_unused = {jdo[37:35], jdo[2:0]};

    always_comb begin
        any_strobe   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
        multi_strobe = (take_action_ocimem_a & take_action_ocimem_b) |
                       (take_action_ocimem_a & take_no_action_ocimem_a) |
                       (take_action_ocimem_b & take_no_action_ocimem_a);
        // A write grant frees the slot in the same cycle; a read grant does not.
        slot_free    = (~pending | slot_wr_grant) & ~jtag_rd_active;
        accept       = any_strobe & slot_free;
        next_op      = OP_RD_INC;
        next_ld      = 1'b0;
        if (take_action_ocimem_b) begin
            next_op = OP_WR_INC;
        end else if (take_action_ocimem_a) begin
            next_op = OP_RD;
            next_ld = jdo[JDO_LDADDR_BIT];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending   <= 1'b0;
            pend_op   <= OP_RD;
            pend_ld   <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
            overrun   <= 1'b0;
        end else begin
            if (accept) begin
                pending   <= 1'b1;
                pend_op   <= next_op;
                pend_ld   <= next_ld;
                pend_addr <= jdo[JDO_ADDR_LSB +: ADDR_W];
                pend_data <= jdo[JDO_DATA_MSB:JDO_DATA_LSB];
            end else if (slot_grant) begin
                pending <= 1'b0;
            end
            if (multi_strobe | (any_strobe & ~slot_free)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/system_qsys_nios2_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between the CPU debug slave and
// JTAG debugger actions, with alternating priority on ties.
module system_qsys_nios2_ocimem_arbiter
    import system_qsys_nios2_oci_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned RAM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    input  logic [3:0]        cpu_byteenable,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [3:0]        ram_byteenable,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              jtag_busy,
    output logic              jtag_overrun
);

    if (RAM_RD_LAT != 1 || ADDR_W < 1 || ADDR_W > 8) begin : g_param_check
        $error("unsupported RAM_RD_LAT or ADDR_W");
    end

    state_t            state;
    grant_t            last_grant;
    logic              rd_inc;
    logic              pending;
    op_t               pend_op;
    logic              pend_ld;
    logic [ADDR_W-1:0] pend_addr;
    logic [31:0]       pend_data;
    logic              cpu_req;
    logic              grant_j;
    logic              grant_c;
    logic              jtag_wr;
    logic [ADDR_W-1:0] jtag_addr;

    system_qsys_nios2_ocimem_jtag_req #(.ADDR_W(ADDR_W)) u_jtag_req (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .slot_grant              (grant_j),
        .slot_wr_grant           (jtag_wr),
        .jtag_rd_active          (state == JTAG_RD),
        .pending                 (pending),
        .pend_op                 (pend_op),
        .pend_ld                 (pend_ld),
        .pend_addr               (pend_addr),
        .pend_data               (pend_data),
        .overrun                 (jtag_overrun)
    );

    always_comb begin
        cpu_req   = cpu_read | cpu_write;
        grant_j   = (state == IDLE) & pending & (~cpu_req | (last_grant == GRANT_CPU));
        grant_c   = (state == IDLE) & cpu_req & ~grant_j;
        jtag_addr = pend_ld ? pend_addr : MonAReg;
        jtag_wr   = grant_j & (pend_op == OP_WR_INC);

        ram_addr        = grant_j ? jtag_addr : cpu_address;
        ram_wren        = jtag_wr | (grant_c & cpu_write);
        ram_byteenable  = grant_j ? 4'hF : cpu_byteenable;
        ram_wdata       = grant_j ? pend_data : cpu_writedata;
        cpu_readdata    = (state == CPU_RD) ? ram_rdata : '0;
        cpu_waitrequest = ~((grant_c & cpu_write) | (state == CPU_RD));
        jtag_busy       = pending | (state == JTAG_RD);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= GRANT_CPU;
            rd_inc     <= 1'b0;
            MonDReg    <= '0;
            MonAReg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_j) begin
                        last_grant <= GRANT_JTAG;
                        if (pend_op == OP_WR_INC) begin
                            MonAReg <= jtag_addr + 1'b1;
                        end else begin
                            MonAReg <= jtag_addr;
                            rd_inc  <= (pend_op == OP_RD_INC);
                            state   <= JTAG_RD;
                        end
                    end else if (grant_c) begin
                        last_grant <= GRANT_CPU;
                        if (!cpu_write) begin
                            state <= CPU_RD;
                        end
                    end
                end
                CPU_RD: begin
                    state <= IDLE;
                end
                JTAG_RD: begin
                    MonDReg <= ram_rdata;
                    if (rd_inc) begin
                        MonAReg <= MonAReg + 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_system_qsys_nios2_ocimem_arbiter.sv
// Directed bench for the OCI memory arbiter with a behavioural
// registered-read RAM attached to the ram_* port.
module tb_system_qsys_nios2_ocimem_arbiter;

    logic        clk;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [7:0]  cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_writedata;
    logic [3:0]  cpu_byteenable;
    logic [31:0] cpu_readdata;
    logic        cpu_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] MonDReg;
    logic [7:0]  MonAReg;
    logic        jtag_busy;
    logic        jtag_overrun;

    logic [31:0] mem [256];
    int n_chk  = 0;
    int n_pass = 0;

    system_qsys_nios2_ocimem_arbiter #(.ADDR_W(8), .RAM_RD_LAT(1)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_byteenable          (cpu_byteenable),
        .cpu_readdata            (cpu_readdata),
        .cpu_waitrequest         (cpu_waitrequest),
        .ram_addr                (ram_addr),
        .ram_wren                (ram_wren),
        .ram_byteenable          (ram_byteenable),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg),
        .jtag_busy               (jtag_busy),
        .jtag_overrun            (jtag_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_byteenable[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
        else n_pass++;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic logic [37:0] jdo_addr(input logic ld, input logic [7:0] a);
        logic [37:0] j;
        j = '0;
        j[34] = ld;
        j[17:10] = a;
        return j;
    endfunction

    function automatic logic [37:0] jdo_data(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    // kind: 0 = action_a, 1 = action_b, 2 = no_action_a; one cycle wide.
    task automatic jtag_strobe(input int kind, input logic [37:0] j);
        jdo = j;
        take_action_ocimem_a    = (kind == 0);
        take_action_ocimem_b    = (kind == 1);
        take_no_action_ocimem_a = (kind == 2);
        nxt();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        logic done;
        done = 1'b0;
        cpu_address = a; cpu_writedata = d; cpu_byteenable = be; cpu_write = 1'b1;
        for (int i = 0; i < 8 && !done; i++) begin
            mid();
            if (!cpu_waitrequest) done = 1'b1;
            nxt();
        end
        cpu_write = 1'b0;
        check("cpu_wr_ack", {31'd0, done}, 32'd1);
    endtask

    task automatic cpu_rd(input logic [7:0] a, output logic [31:0] d);
        logic done;
        done = 1'b0;
        d = '0;
        cpu_address = a; cpu_read = 1'b1;
        for (int i = 0; i < 8 && !done; i++) begin
            mid();
            if (!cpu_waitrequest) begin
                d = cpu_readdata;
                done = 1'b1;
            end
            nxt();
        end
        cpu_read = 1'b0;
        check("cpu_rd_ack", {31'd0, done}, 32'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        nxt();
        nxt();
        reset_n = 1'b1;
        nxt();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0;
        cpu_writedata = '0; cpu_byteenable = '0;
        nxt();
        nxt();
        check("rst_MonDReg", MonDReg, 32'h0);
        check("rst_MonAReg", {24'd0, MonAReg}, 32'h0);
        check("rst_busy", {31'd0, jtag_busy}, 32'h0);
        check("rst_overrun", {31'd0, jtag_overrun}, 32'h0);
        check("rst_waitreq", {31'd0, cpu_waitrequest}, 32'h1);
        check("rst_wren", {31'd0, ram_wren}, 32'h0);
        check("rst_readdata", cpu_readdata, 32'h0);
        reset_n = 1'b1;
        nxt();
        mid();
        check("idle_waitreq", {31'd0, cpu_waitrequest}, 32'h1);
        nxt();

        // JTAG load-address read of 0x20
        cpu_wr(8'h20, 32'hDEADBEEF, 4'hF);
        jtag_strobe(0, jdo_addr(1'b1, 8'h20));
        mid();
        check("t1_ram_addr", {24'd0, ram_addr}, 32'h20);
        check("t1_busy", {31'd0, jtag_busy}, 32'h1);
        nxt();
        nxt();
        check("t1_MonDReg", MonDReg, 32'hDEADBEEF);
        check("t1_MonAReg", {24'd0, MonAReg}, 32'h20);
        check("t1_busy_done", {31'd0, jtag_busy}, 32'h0);

        // JTAG writes across the address wrap
        jtag_strobe(0, jdo_addr(1'b1, 8'hFE));
        nxt(); nxt(); nxt();
        check("t2_MonAReg_ld", {24'd0, MonAReg}, 32'hFE);
        for (int k = 1; k <= 3; k++) begin
            logic [7:0] ea;
            ea = 8'hFE + 8'(k - 1);
            jtag_strobe(1, jdo_data(32'(k)));
            mid();
            check("t2_wren", {31'd0, ram_wren}, 32'h1);
            check("t2_addr", {24'd0, ram_addr}, {24'd0, ea});
            check("t2_be", {28'd0, ram_byteenable}, 32'hF);
            check("t2_wdata", ram_wdata, 32'(k));
            nxt(); nxt(); nxt();
        end
        check("t2_MonAReg_wrap", {24'd0, MonAReg}, 32'h01);
        cpu_rd(8'hFE, rd); check("t2_mem_FE", rd, 32'd1);
        cpu_rd(8'hFF, rd); check("t2_mem_FF", rd, 32'd2);
        cpu_rd(8'h00, rd); check("t2_mem_00", rd, 32'd3);

        cpu_wr(8'h10, 32'hAAAA0010, 4'hF);
        cpu_wr(8'h01, 32'h11111111, 4'hF);
        cpu_wr(8'h02, 32'h22222222, 4'hF);
        cpu_wr(8'h05, 32'hFFFFFFFF, 4'hF);

        // First tie after reset: JTAG wins
        do_reset();
        jtag_strobe(2, '0);
        cpu_address = 8'h10; cpu_read = 1'b1;
        mid();
        check("t3_tie1_addr", {24'd0, ram_addr}, 32'h00);
        check("t3_tie1_wait", {31'd0, cpu_waitrequest}, 32'h1);
        nxt(); mid();
        check("t3_jrd_wait", {31'd0, cpu_waitrequest}, 32'h1);
        nxt(); mid();
        check("t3_cpu_grant_addr", {24'd0, ram_addr}, 32'h10);
        check("t3_MonDReg", MonDReg, 32'h3);
        check("t3_MonAReg", {24'd0, MonAReg}, 32'h1);
        nxt(); mid();
        check("t3_cpu_done_wait", {31'd0, cpu_waitrequest}, 32'h0);
        check("t3_cpu_rdata", cpu_readdata, 32'hAAAA0010);
        nxt();
        cpu_read = 1'b0;
        jtag_strobe(2, '0);
        nxt(); nxt(); nxt();
        check("t3_solo_MonDReg", MonDReg, 32'h11111111);

        // Second tie with JTAG last granted: CPU wins
        jtag_strobe(2, '0);
        cpu_address = 8'h10; cpu_read = 1'b1;
        mid();
        check("t3_tie2_addr", {24'd0, ram_addr}, 32'h10);
        check("t3_tie2_wait", {31'd0, cpu_waitrequest}, 32'h1);
        nxt(); mid();
        check("t3_tie2_done", {31'd0, cpu_waitrequest}, 32'h0);
        check("t3_tie2_rdata", cpu_readdata, 32'hAAAA0010);
        check("t3_tie2_busy", {31'd0, jtag_busy}, 32'h1);
        nxt();
        cpu_read = 1'b0;
        mid();
        check("t3_tie2_jaddr", {24'd0, ram_addr}, 32'h02);
        nxt(); nxt(); mid();
        check("t3_tie2_MonDReg", MonDReg, 32'h22222222);
        check("t3_tie2_MonAReg", {24'd0, MonAReg}, 32'h03);
        check("t4_overrun_pre", {31'd0, jtag_overrun}, 32'h0);
        nxt();

        // Back-to-back strobes: second dropped
        jdo = jdo_addr(1'b1, 8'h20);
        take_action_ocimem_a = 1'b1;
        nxt();
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b1;
        nxt();
        take_no_action_ocimem_a = 1'b0;
        mid();
        check("t4_overrun", {31'd0, jtag_overrun}, 32'h1);
        nxt(); mid();
        check("t4_MonDReg", MonDReg, 32'hDEADBEEF);
        check("t4_MonAReg", {24'd0, MonAReg}, 32'h20);
        check("t4_busy", {31'd0, jtag_busy}, 32'h0);
        nxt(); nxt(); nxt();
        check("t4_overrun_sticky", {31'd0, jtag_overrun}, 32'h1);

        // CPU partial write
        cpu_address = 8'h05; cpu_writedata = 32'h12345678;
        cpu_byteenable = 4'b0011; cpu_write = 1'b1;
        mid();
        check("t5_wren", {31'd0, ram_wren}, 32'h1);
        check("t5_be", {28'd0, ram_byteenable}, 32'h3);
        check("t5_addr", {24'd0, ram_addr}, 32'h05);
        check("t5_wdata", ram_wdata, 32'h12345678);
        check("t5_wait", {31'd0, cpu_waitrequest}, 32'h0);
        nxt();
        cpu_write = 1'b0;
        mid();
        check("t5_wren_after", {31'd0, ram_wren}, 32'h0);
        check("t5_wait_after", {31'd0, cpu_waitrequest}, 32'h1);
        nxt();
        cpu_rd(8'h05, rd);
        check("t5_mem_05", rd, 32'hFFFF5678);

        // Reset while in JTAG_RD
        jtag_strobe(0, jdo_addr(1'b1, 8'h01));
        nxt();
        check("t6_busy_pre", {31'd0, jtag_busy}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("t6_MonDReg", MonDReg, 32'h0);
        check("t6_MonAReg", {24'd0, MonAReg}, 32'h0);
        check("t6_busy", {31'd0, jtag_busy}, 32'h0);
        check("t6_overrun", {31'd0, jtag_overrun}, 32'h0);
        check("t6_waitreq", {31'd0, cpu_waitrequest}, 32'h1);
        check("t6_wren", {31'd0, ram_wren}, 32'h0);
        nxt();
        reset_n = 1'b1;
        nxt();
        check("t6_MonDReg_hold", MonDReg, 32'h0);
        jtag_strobe(2, '0);
        nxt(); nxt();
        check("t6_post_MonDReg", MonDReg, 32'h3);
        check("t6_post_MonAReg", {24'd0, MonAReg}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
